// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-cycle lookup, one-edge training, two saturating perf counters.
// No backpressure: one update accepted every cycle. Define BTB_FORWARD_EN to forward same-cycle updates to the lookup.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_predicted,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic [31:0]           update_count,
  output logic [31:0]           mispredict_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = DATA_WIDTH - IDX_BITS - 2;

  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [DATA_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [1:0]            ctr_d    [ENTRIES];
  logic [31:0]           upd_cnt_q, upd_cnt_d;
  logic [31:0]           mis_cnt_q, mis_cnt_d;

  logic [IDX_BITS-1:0]   lidx, uidx;
  logic [TAG_W-1:0]      ltag, utag;
  logic                  u_hit;
  logic                  new_valid;
  logic [TAG_W-1:0]      new_tag;
  logic [DATA_WIDTH-1:0] new_target;
  logic [1:0]            new_ctr;
  logic                  lk_valid;
  logic [TAG_W-1:0]      lk_tag;
  logic [DATA_WIDTH-1:0] lk_target;
  logic [1:0]            lk_ctr;
  logic                  lk_hit;
  logic                  unused_bits;

  assign lidx        = PC[IDX_BITS+1:2];
  assign ltag        = PC[DATA_WIDTH-1:IDX_BITS+2];
  assign uidx        = update_pc[IDX_BITS+1:2];
  assign utag        = update_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign unused_bits = ^{PC[1:0], update_pc[1:0]};

  // Post-update view of the entry at uidx; feeds both the next state and the forward path.
  always_comb begin
    u_hit      = valid_q[uidx] && (tag_q[uidx] == utag);
    new_valid  = valid_q[uidx];
    new_tag    = tag_q[uidx];
    new_target = target_q[uidx];
    new_ctr    = ctr_q[uidx];
    if (u_hit) begin
      if (update_taken) begin
        new_ctr    = (ctr_q[uidx] == 2'b11) ? 2'b11 : ctr_q[uidx] + 2'b01;
        new_target = update_target;
      end else begin
        new_ctr    = (ctr_q[uidx] == 2'b00) ? 2'b00 : ctr_q[uidx] - 2'b01;
      end
    end else if (update_taken) begin
      new_valid  = 1'b1;
      new_tag    = utag;
      new_target = update_target;
      new_ctr    = 2'b10;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (update_en) begin
      valid_d[uidx]  = new_valid;
      tag_d[uidx]    = new_tag;
      target_d[uidx] = new_target;
      ctr_d[uidx]    = new_ctr;
      if (upd_cnt_q != 32'hFFFF_FFFF) upd_cnt_d = upd_cnt_q + 32'd1;
      if ((update_predicted != update_taken) && (mis_cnt_q != 32'hFFFF_FFFF))
        mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_comb begin
    lk_valid  = valid_q[lidx];
    lk_tag    = tag_q[lidx];
    lk_target = target_q[lidx];
    lk_ctr    = ctr_q[lidx];
`ifdef BTB_FORWARD_EN
    // Reset gates the forward path so outputs stay quiet while rst is high.
    if (update_en && !rst && (update_pc[DATA_WIDTH-1:2] == PC[DATA_WIDTH-1:2])) begin
      lk_valid  = new_valid;
      lk_tag    = new_tag;
      lk_target = new_target;
      lk_ctr    = new_ctr;
    end
`endif
    lk_hit        = lk_valid && (lk_tag == ltag);
    predict_taken = lk_hit && lk_ctr[1];
    branch_target = lk_hit ? lk_target : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign update_count     = upd_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: expectations are queued as stimulus is driven and drained once outputs settle.
module tb_branch_predictor;

  typedef enum logic [1:0] {K_PT, K_BT, K_UC, K_MC} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_predicted = 1'b0;
  logic        predict_taken;
  logic [31:0] branch_target;
  logic [31:0] update_count;
  logic [31:0] mispredict_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

`ifdef BTB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC               (pc),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_predicted (update_predicted),
    .predict_taken    (predict_taken),
    .branch_target    (branch_target),
    .update_count     (update_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input kind_e kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic expect_lookup(input string tag, input logic pt, input logic [31:0] bt);
    push({tag, ".pt"}, K_PT, {31'd0, pt});
    push({tag, ".bt"}, K_BT, bt);
  endtask

  task automatic expect_counts(input string tag, input logic [31:0] uc, input logic [31:0] mc);
    push({tag, ".uc"}, K_UC, uc);
    push({tag, ".mc"}, K_MC, mc);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_PT:    obs = {31'd0, predict_taken};
        K_BT:    obs = branch_target;
        K_UC:    obs = update_count;
        default: obs = mispredict_count;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; the update lands at the next rising edge.
  task automatic cyc(input logic [31:0] lpc, input logic en, input logic [31:0] upc,
                     input logic tk, input logic [31:0] tgt, input logic pred);
    @(negedge clk);
    pc               = lpc;
    update_en        = en;
    update_pc        = upc;
    update_taken     = tk;
    update_target    = tgt;
    update_predicted = pred;
  endtask

  task automatic idle(input logic [31:0] lpc);
    cyc(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    pc = 32'h100;
    #1;
    expect_lookup("rst_init", 1'b0, 32'h0);
    expect_counts("rst_init", 32'd0, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle hazard on an empty BTB
    cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    expect_lookup("hazard", FWD, FWD ? 32'h80 : 32'h0);
    drain();

    // Allocate and predict
    idle(32'h100);
    expect_lookup("alloc_hit", 1'b1, 32'h80);
    expect_counts("alloc", 32'd1, 32'd1);
    drain();
    idle(32'h104);
    expect_lookup("alloc_neighbour", 1'b0, 32'h0);
    drain();

    // Saturation and hysteresis: 10 -> 11 -> 11 -> 10
    cyc(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
    cyc(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
    cyc(32'h0, 1'b1, 32'h100, 1'b0, 32'h0,  1'b1);
    expect_lookup("sat_unrelated", 1'b0, 32'h0);
    drain();
    idle(32'h100);
    expect_lookup("sat_one_nt", 1'b1, 32'h80);
    expect_counts("sat", 32'd4, 32'd2);
    drain();
    cyc(32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    idle(32'h100);
    expect_lookup("sat_two_nt", 1'b0, 32'h80);
    drain();

    // Aliasing: 0x100 and 0x140 share index 0
    cyc(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    idle(32'h100);
    expect_lookup("alias_retrain", 1'b1, 32'h80);
    drain();
    cyc(32'h0, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0);
    idle(32'h100);
    expect_lookup("alias_evicted", 1'b0, 32'h0);
    drain();
    idle(32'h140);
    expect_lookup("alias_new", 1'b1, 32'h200);
    drain();
    cyc(32'h0, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0);
    idle(32'h140);
    expect_lookup("alias_nt_miss", 1'b1, 32'h200);
    drain();

    // Asynchronous reset mid-run, with an update presented across the edge
    cyc(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0);
    rst = 1'b1;
    expect_lookup("rst_async", 1'b0, 32'h0);
    expect_counts("rst_async", 32'd0, 32'd0);
    drain();
    @(posedge clk);
    #1;
    expect_lookup("rst_edge", 1'b0, 32'h0);
    drain();
    idle(32'h140);
    rst = 1'b0;
    #1;
    idle(32'h140);
    expect_lookup("rst_after", 1'b0, 32'h0);
    expect_counts("rst_after", 32'd0, 32'd0);
    drain();

    // Counters: 5 updates, 2 mispredicted (not-taken misses leave the BTB alone)
    for (int i = 0; i < 5; i++)
      cyc(32'h0, 1'b1, 32'h300, 1'b0, 32'h0, (i == 1 || i == 3));
    idle(32'h300);
    expect_lookup("cnt_nt_miss", 1'b0, 32'h0);
    expect_counts("cnt", 32'd5, 32'd2);
    drain();

    // Counter saturation
    @(negedge clk);
    force dut.upd_cnt_q = 32'hFFFF_FFFF;
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.upd_cnt_q;
    release dut.mis_cnt_q;
    cyc(32'h0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0);
    idle(32'h300);
    expect_counts("cnt_sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_lookup("cnt_sat_alloc", 1'b1, 32'h400);
    drain();

    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating counters, sitting beside the fetch PC logic. It is indexed combinationally by the current fetch PC and returns `predict_taken` and `branch_target` in the same cycle, which the PC-select logic uses to steer the next PC. It is trained at the clock edge by resolved branch and jump outcomes from the execute stage. It keeps two saturating performance counters: resolved updates and mispredicts.

## Interface

Parameters:
- `DATA_WIDTH`, 32, width of PCs and targets.
- `ENTRIES`, 16, number of BTB entries; power of two, ≥2. `IDX_BITS = log2(ENTRIES)`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `PC` in DATA_WIDTH: current fetch PC (lookup address).
- `update_en` in 1: execute stage has a resolved control-flow instruction this cycle.
- `update_pc` in DATA_WIDTH: PC of the resolved instruction.
- `update_taken` in 1: actual outcome.
- `update_target` in DATA_WIDTH: actual target when taken.
- `update_predicted` in 1: prediction that was issued for this instruction.
- `predict_taken` out 1: predicted taken for `PC`.
- `branch_target` out DATA_WIDTH: predicted target for `PC`.
- `update_count` out 32: number of accepted updates, saturating.
- `mispredict_count` out 32: number of mispredicted updates, saturating.

## Operation

- Each entry holds `valid`, `tag`, `target` and `ctr[1:0]`.
- Entry fields:
  - index = `addr[IDX_BITS+1:2]`
  - tag = `addr[DATA_WIDTH-1:IDX_BITS+2]`
  - `addr[1:0]` is ignored.
- Lookup is purely combinational:
  - hit = `valid[idx] && tag[idx]==PC tag`
  - `predict_taken` = `hit && ctr[idx][1]`
  - `branch_target` = `target[idx]` when hit, else 0
- Update at the rising edge when `update_en` = 1; `uidx` is the index of `update_pc`:
  - **Tag hit, taken:** `ctr` increments, saturating at 2'b11; `target` ← `update_target`.
  - **Tag hit, not taken:** `ctr` decrements, saturating at 2'b00; `target` is unchanged.
  - **Miss (invalid or tag differs), taken:** allocate the entry, replacing any occupant. Set `valid`=1, `tag`, `target` ← `update_target`, `ctr` = 2'b10.
  - **Miss, not taken:** no change to the BTB.
- Performance counters, when `update_en` = 1:
  - `update_count` increments.
  - `mispredict_count` increments if `update_predicted != update_taken`.
  - Both hold at 32'hFFFF_FFFF; they never wrap.
- Reset (asynchronous, any time, including mid-update):
  - All `valid` cleared; all `ctr` = 2'b01; `target`/`tag` = 0; both counters = 0.
  - Therefore `predict_taken` = 0 and `branch_target` = 0 while `rst` is high.
  - An update coinciding with reset is discarded.

## Timing

- Lookup latency is zero cycles (combinational from `PC`); there is no registered output on the lookup path.
- Update latency is one edge: the effect is visible to a lookup in the cycle after the edge.
- Lookup and update to the same index in the same cycle:
  - Without forwarding, the lookup sees the pre-update entry.
  - See Configuration for the forwarding option.
- One update per cycle maximum; no backpressure; `update_en` is never stalled.

## Configuration

- `BTB_FORWARD_EN` defined:
  - When `update_en` = 1 and `update_pc` matches `PC` (index and tag), the lookup uses the post-update values for that cycle.
  - Those values are the new `ctr`, `target` and `valid` computed by the update rules above.
  - This adds a combinational path from the update inputs to `predict_taken`/`branch_target`.
- `BTB_FORWARD_EN` undefined: the lookup always reads stored state (pre-update).

## Test plan

- **Reset:** assert `rst` mid-run after training.
  - Expect `predict_taken`=0, `branch_target`=0 and both counters = 0 immediately (asynchronous), and after release.
- **Allocate and predict:** update `update_pc`=0x100, taken, target 0x80.
  - Next cycle, `PC`=0x100 → `predict_taken`=1, `branch_target`=0x80.
  - `PC`=0x104 → `predict_taken`=0.
- **Saturation / hysteresis:**
  - From `ctr`=2'b10, two taken updates then one not-taken → still predicts taken (`ctr` 11→10).
  - Then one more not-taken → `predict_taken`=0; `branch_target` is still 0x80 (hit).
- **Aliasing:** with ENTRIES=16, train 0x100 taken→0x80, then update 0x140 (same index, different tag) taken→0x200.
  - `PC`=0x100 → miss, `predict_taken`=0.
  - `PC`=0x140 → 0x200.
  - A not-taken miss to 0x180 leaves the 0x140 entry intact.
- **Same-cycle hazard:** `PC`=0x100 and update 0x100 taken→0x80 in the same cycle on an empty BTB.
  - Without `BTB_FORWARD_EN` → `predict_taken`=0 that cycle.
  - With `BTB_FORWARD_EN` → `predict_taken`=1, `branch_target`=0x80.
- **Counters:** issue 5 updates, 2 with `update_predicted`≠`update_taken` → `update_count`=5, `mispredict_count`=2.
  - Force the counters to 0xFFFF_FFFF and issue a further mispredicted update → both remain at 0xFFFF_FFFF.
